// File: rtl/lcd_value_display_pkg.sv
// Shared types, LCD command constants and helpers for the LCD value display.
package lcd_value_display_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    SET_ADDR,
    WR_CHAR
  } state_t;

  typedef enum logic [2:0] {
    WE_IDLE,
    WE_LOAD,
    WE_SETUP,
    WE_PULSE,
    WE_WAIT
  } we_phase_t;

  localparam logic [7:0] CMD_FUNC_SET  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear display (long execution)
  localparam logic [7:0] CMD_ENTRY     = 8'h06;  // entry mode: increment
  localparam logic [7:0] CMD_SET_ADDR0 = 8'h80;  // DDRAM address 0 (row 0, col 0)

  localparam logic [1:0] LAST_INIT_IDX = 2'd3;

  // Init command ROM, issued in index order 0..3.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_CLEAR;
      default: cmd = CMD_ENTRY;
    endcase
    return cmd;
  endfunction

  // One hex nibble to its upper-case ASCII character.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] v);
    logic [7:0] ch;
    if (v < 4'd10) ch = 8'h30 + {4'h0, v};
    else           ch = 8'h37 + {4'h0, v};
    return ch;
  endfunction

endpackage

// File: rtl/lcd_value_display_if.sv
// Counter-value input, busy flag and HD44780 parallel bus of the LCD display block.
interface lcd_value_display_if;
  logic [3:0] value;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  modport master (
    input  value,
    output busy, lcd_rs, lcd_rw, lcd_e, lcd_data
  );

  modport slave (
    output value,
    input  busy, lcd_rs, lcd_rw, lcd_e, lcd_data
  );
endinterface

// File: rtl/lcd_value_display_write_engine.sv
// Single LCD bus write: set up rs/data, strobe e for T_PW cycles, then wait.
// done is combinational so the sequencer can chain the next write on the same edge.
module lcd_write_engine
  import lcd_value_display_pkg::*;
#(
  parameter int unsigned T_PW = 50,
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_rs,
  input  logic [7:0]    i_data,
  input  logic [CW-1:0] i_wait_cycles,
  output logic          o_done,
  output logic          o_lcd_rs,
  output logic [7:0]    o_lcd_data,
  output logic          o_lcd_e
);

  we_phase_t     r_phase;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_wait;
  logic          r_pend_rs;
  logic [7:0]    r_pend_data;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_e;
  logic          w_accept;

  assign o_done     = (r_phase == WE_WAIT) && (r_cnt == '0);
  assign w_accept   = i_start && ((r_phase == WE_IDLE) || o_done);
  assign o_lcd_rs   = r_rs;
  assign o_lcd_data = r_data;
  assign o_lcd_e    = r_e;

  // Write phase sequencing: accept -> drive bus -> raise e -> pulse -> post-write wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= WE_IDLE;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_pend_rs   <= 1'b0;
      r_pend_data <= '0;
      r_rs        <= 1'b0;
      r_data      <= '0;
      r_e         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_rs   <= i_rs;
        r_pend_data <= i_data;
        r_wait      <= i_wait_cycles;
      end
      case (r_phase)
        WE_IDLE: begin
          if (i_start) r_phase <= WE_LOAD;
        end
        WE_LOAD: begin
          r_rs    <= r_pend_rs;
          r_data  <= r_pend_data;
          r_phase <= WE_SETUP;
        end
        WE_SETUP: begin
          r_e     <= 1'b1;
          r_cnt   <= CW'(T_PW - 1);
          r_phase <= WE_PULSE;
        end
        WE_PULSE: begin
          if (r_cnt == '0) begin
            r_e     <= 1'b0;
            r_cnt   <= r_wait - CW'(1);
            r_phase <= WE_WAIT;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        WE_WAIT: begin
          if (r_cnt == '0) r_phase <= i_start ? WE_LOAD : WE_IDLE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        default: r_phase <= WE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_value_display.sv
// Keeps a 4-bit value shown as one hex digit at row 0, column 0 of an HD44780 LCD:
// power-up delay, init command sequence, then rewrite the digit whenever it changes.
module lcd_value_display #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned T_PWRUP = 1_500_000,
  parameter int unsigned T_PW    = 50,
  parameter int unsigned T_CMD   = 4_000,
  parameter int unsigned T_CLR   = 164_000
) (
  input logic              clk,
  input logic              rst,
  lcd_value_display_if.master bus
);
  import lcd_value_display_pkg::*;

  localparam int unsigned T_MAX_A = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int unsigned T_MAX_B = (T_CMD > T_PW) ? T_CMD : T_PW;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned CW      = $clog2(T_MAX) + 1;

  // Every delay is loaded as (n - 1), so none may be zero.
  if (CLK_HZ == 0 || T_PWRUP == 0 || T_PW == 0 || T_CMD == 0 || T_CLR == 0) begin : g_param_check
    $error("lcd_value_display: clock frequency and all delays must be non-zero");
  end

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_shown;
  logic          r_dirty;
  logic          r_busy;

  logic          w_start;
  logic          w_rs;
  logic [7:0]    w_data;
  logic [CW-1:0] w_wait;
  logic          w_done;
  logic          w_update;
  logic [1:0]    w_idx_next;
  logic          w_lcd_rs;
  logic [7:0]    w_lcd_data;
  logic          w_lcd_e;

  assign w_update   = r_dirty || (bus.value != r_shown);
  assign w_idx_next = r_idx + 2'd1;

  assign bus.busy     = r_busy;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_rs   = w_lcd_rs;
  assign bus.lcd_data = w_lcd_data;
  assign bus.lcd_e    = w_lcd_e;

  // Next-write selection: the write that follows is launched in the cycle done is seen,
  // so the command mux describes the upcoming write rather than the one finishing.
  always_comb begin
    w_start = 1'b0;
    w_rs    = 1'b0;
    w_data  = '0;
    w_wait  = CW'(T_CMD);
    case (r_state)
      PWR_WAIT: begin
        if (r_cnt == '0) begin
          w_start = 1'b1;
          w_data  = init_cmd(2'd0);
        end
      end
      INIT: begin
        if (w_done && (r_idx != LAST_INIT_IDX)) begin
          w_start = 1'b1;
          w_data  = init_cmd(w_idx_next);
          if (init_cmd(w_idx_next) == CMD_CLEAR) w_wait = CW'(T_CLR);
        end
      end
      IDLE: begin
        if (w_update) begin
          w_start = 1'b1;
          w_data  = CMD_SET_ADDR0;
        end
      end
      SET_ADDR: begin
        if (w_done) begin
          w_start = 1'b1;
          w_rs    = 1'b1;
          w_data  = hex_to_ascii(r_shown);
        end
      end
      default: ;
    endcase
  end

  // Sequencing FSM: power-up wait, init ROM walk, then idle/update loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PWR_WAIT;
      r_cnt   <= CW'(T_PWRUP - 1);
      r_idx   <= '0;
      r_shown <= '0;
      r_dirty <= 1'b1;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        PWR_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= INIT;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        INIT: begin
          if (w_done) begin
            if (r_idx == LAST_INIT_IDX) begin
              r_state <= IDLE;
              r_dirty <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= w_idx_next;
            end
          end
        end
        IDLE: begin
          if (w_update) begin
            r_shown <= bus.value;
            r_dirty <= 1'b0;
            r_state <= SET_ADDR;
            r_busy  <= 1'b1;
          end
        end
        SET_ADDR: begin
          if (w_done) r_state <= WR_CHAR;
        end
        WR_CHAR: begin
          if (w_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= PWR_WAIT;
      endcase
    end
  end

  lcd_write_engine #(
    .T_PW (T_PW),
    .CW   (CW)
  ) u_write_engine (
    .clk           (clk),
    .rst           (rst),
    .i_start       (w_start),
    .i_rs          (w_rs),
    .i_data        (w_data),
    .i_wait_cycles (w_wait),
    .o_done        (w_done),
    .o_lcd_rs      (w_lcd_rs),
    .o_lcd_data    (w_lcd_data),
    .o_lcd_e       (w_lcd_e)
  );

endmodule
